mux_vc_arb: RTL and testbench

Transmit-side counterpart of the VC-ID demultiplexer. It drains two per-VC FIFOs (VC0 and VC1) into a single 6-bit word stream toward the link. VC0 has strict priority, tempered by a weighted anti-starvation rule for VC1. The output is registered and the block honours downstream backpressure. It sits between the VC0/VC1 FIFOs and the egress FIFO/serializer, mirroring the demux at the far end.

---
 rtl/vc_pkg.sv | 17 +
 rtl/mux_vc_arb_if.sv | 26 ++
 rtl/vc_arb_ctrl.sv | 71 +++++++
 rtl/mux_vc_arb.sv | 66 ++++++
 tb/tb_mux_vc_arb.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_pkg.sv
// Shared definitions for the VC mux/demux pair: arbitration states, word layout defaults
// and VC index constants.
package vc_pkg;

  localparam int unsigned BwDefault     = 6;
  localparam int unsigned VcBitDefault  = 5;
  localparam int unsigned WeightDefault = 3;

  localparam int unsigned Vc0Idx = 0;
  localparam int unsigned Vc1Idx = 1;

  typedef enum logic [0:0] {
    StServeVc0 = 1'b0,
    StForceVc1 = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux_vc_arb_if.sv
// Bundle of the two FIFO read ports, the pause input and the registered egress stream.
interface mux_vc_arb_if #(
  parameter int unsigned BW = vc_pkg::BwDefault
);
  logic [BW-1:0] data_vc0;
  logic          empty_vc0;
  logic [BW-1:0] data_vc1;
  logic          empty_vc1;
  logic          pause;
  logic          pop_vc0;
  logic          pop_vc1;
  logic [BW-1:0] data_out;
  logic          valid_out;

  // Arbiter side
  modport master (
    input  data_vc0, empty_vc0, data_vc1, empty_vc1, pause,
    output pop_vc0, pop_vc1, data_out, valid_out
  );

  // FIFO / egress side
  modport slave (
    output data_vc0, empty_vc0, data_vc1, empty_vc1, pause,
    input  pop_vc0, pop_vc1, data_out, valid_out
  );
endinterface

// File: rtl/vc_arb_ctrl.sv
// Arbitration control: VC0 strict priority with a forced VC1 slot after WEIGHT consecutive
// VC0 grants while VC1 is waiting. Pops are combinational from state and flags.
module vc_arb_ctrl
  import vc_pkg::*;
#(
  parameter int unsigned WEIGHT = WeightDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic empty_vc0,
  input  logic empty_vc1,
  input  logic pause,
  output logic pop_vc0,
  output logic pop_vc1
);

  if (WEIGHT < 1 || WEIGHT > 15) begin : g_bad_weight
    $error("vc_arb_ctrl: WEIGHT must be in 1..15");
  end

  localparam logic [3:0] CntLast = 4'(WEIGHT - 1);

  arb_state_e state_q;
  logic [3:0] cnt_q;

  // Grant decode; nothing is popped while paused or in reset
  always_comb begin
    pop_vc0 = 1'b0;
    pop_vc1 = 1'b0;
    if (!reset && !pause) begin
      unique case (state_q)
        StServeVc0: begin
          if (!empty_vc0) begin
            pop_vc0 = 1'b1;
          end else if (!empty_vc1) begin
            pop_vc1 = 1'b1;
          end
        end
        StForceVc1: pop_vc1 = !empty_vc1;
      endcase
    end
  end

  // State and starvation counter; pause freezes both
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StServeVc0;
      cnt_q   <= '0;
    end else if (!pause) begin
      unique case (state_q)
        StServeVc0: begin
          if (!empty_vc0) begin
            if (empty_vc1) begin
              cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
              cnt_q   <= '0;
              state_q <= StForceVc1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else if (!empty_vc1) begin
            cnt_q <= '0;
          end
        end
        // Leave after one cycle whether or not VC1 still had a word
        StForceVc1: state_q <= StServeVc0;
      endcase
    end
  end

endmodule

// File: rtl/mux_vc_arb.sv
// Two-VC transmit mux: arbitration control plus the data select and registered output stage.
module mux_vc_arb
  import vc_pkg::*;
#(
  parameter int unsigned BW     = BwDefault,
  parameter int unsigned VC_BIT = VcBitDefault,
  parameter int unsigned WEIGHT = WeightDefault
) (
  input logic          clk,
  input logic          reset,
  mux_vc_arb_if.master bus
);

  // The VC bit is carried through untouched; it only has to lie inside the word
  if (VC_BIT >= BW) begin : g_bad_vc_bit
    $error("mux_vc_arb: VC_BIT must be below BW");
  end

  logic          pop_vc0;
  logic          pop_vc1;
  logic          grant;
  logic [BW-1:0] data_in [2];
  logic [BW-1:0] data_sel;
  logic [BW-1:0] data_out_q;
  logic          valid_out_q;

  vc_arb_ctrl #(
    .WEIGHT(WEIGHT)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .empty_vc0(bus.empty_vc0),
    .empty_vc1(bus.empty_vc1),
    .pause    (bus.pause),
    .pop_vc0  (pop_vc0),
    .pop_vc1  (pop_vc1)
  );

  assign data_in[Vc0Idx] = bus.data_vc0;
  assign data_in[Vc1Idx] = bus.data_vc1;

  // Pops are mutually exclusive, so select on pop_vc1 alone
  always_comb begin
    grant    = pop_vc0 | pop_vc1;
    data_sel = pop_vc1 ? data_in[Vc1Idx] : data_in[Vc0Idx];
  end

  // Output register; data holds its last value when nothing is granted
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= grant;
      if (grant) begin
        data_out_q <= data_sel;
      end
    end
  end

  assign bus.pop_vc0   = pop_vc0;
  assign bus.pop_vc1   = pop_vc1;
  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_mux_vc_arb.sv
// Bench for mux_vc_arb: queue-backed show-ahead FIFOs, a history-based arbitration model and
// directed plus random scenarios.
module tb_mux_vc_arb;
  import vc_pkg::*;

  localparam int unsigned BW     = 6;
  localparam int unsigned VC_BIT = 5;
  localparam int unsigned WEIGHT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_vc_arb_if #(.BW(BW)) bus ();

  mux_vc_arb #(
    .BW    (BW),
    .VC_BIT(VC_BIT),
    .WEIGHT(WEIGHT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];

  int n_checks = 0;
  int n_fails  = 0;

  // Model: VC0 grants in a row while VC1 waited, and whether VC1 is owed a slot
  int unsigned   m_run0;
  bit            m_owe1;
  logic [BW-1:0] m_dout;
  logic          m_vout;

  logic          o_pop0, o_pop1, x_pop0, x_pop1, o_vout;
  logic [BW-1:0] o_dout;

  function automatic logic [BW-1:0] mk_word(input bit vc);
    logic [BW-1:0] w;
    w = BW'($urandom);
    w[VC_BIT] = vc;
    return w;
  endfunction

  task automatic drive_fifos();
    bus.empty_vc0 = (q0.size() == 0);
    bus.data_vc0  = (q0.size() != 0) ? q0[0] : '0;
    bus.empty_vc1 = (q1.size() == 0);
    bus.data_vc1  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // One clock: sample pops mid-cycle, step model, apply pops to FIFOs, sample outputs
  task automatic cycle();
    logic g0, g1;
    logic [BW-1:0] h0, h1;
    @(negedge clk);
    o_pop0 = bus.pop_vc0;
    o_pop1 = bus.pop_vc1;
    h0 = bus.data_vc0;
    h1 = bus.data_vc1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset) begin
      m_run0 = 0;
      m_owe1 = 1'b0;
    end else if (bus.pause) begin
      g0 = 1'b0;
    end else if (m_owe1) begin
      m_owe1 = 1'b0;
      g1 = !bus.empty_vc1;
    end else if (!bus.empty_vc0) begin
      g0 = 1'b1;
      if (!bus.empty_vc1) begin
        m_run0++;
        if (m_run0 == WEIGHT) begin
          m_run0 = 0;
          m_owe1 = 1'b1;
        end
      end else begin
        m_run0 = 0;
      end
    end else if (!bus.empty_vc1) begin
      g1 = 1'b1;
      m_run0 = 0;
    end
    x_pop0 = g0;
    x_pop1 = g1;
    @(posedge clk);
    #1;
    if (o_pop0 && q0.size() != 0) q0.delete(0);
    if (o_pop1 && q1.size() != 0) q1.delete(0);
    if (reset) begin
      m_dout = '0;
      m_vout = 1'b0;
    end else if (g0) begin
      m_dout = h0;
      m_vout = 1'b1;
    end else if (g1) begin
      m_dout = h1;
      m_vout = 1'b1;
    end else begin
      m_vout = 1'b0;
    end
    o_dout = bus.data_out;
    o_vout = bus.valid_out;
    drive_fifos();
  endtask

  task automatic flush();
    reset = 1'b1;
    bus.pause = 1'b0;
    q0.delete();
    q1.delete();
    drive_fifos();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [BW-1:0] first;
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk_word(1'b0));
      q1.push_back(mk_word(1'b1));
    end
    drive_fifos();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if ({o_pop0, o_pop1, o_vout, o_dout} !== {1'b0, 1'b0, 1'b0, 6'h00}) begin
        n_fails++;
        $display("FAIL reset_hold: pops=%b%b valid=%b data=%h, required 00 0 00",
                 o_pop0, o_pop1, o_vout, o_dout);
      end
    end
    reset = 1'b0;
    first = q0[0];
    cycle();
    n_checks++;
    if ({o_pop0, o_pop1} !== 2'b10) begin
      n_fails++;
      $display("FAIL reset_first_pop: pops=%b%b, required 10", o_pop0, o_pop1);
    end
    n_checks++;
    if ({o_vout, o_dout} !== {1'b1, first}) begin
      n_fails++;
      $display("FAIL reset_first_word: valid=%b data=%h, required 1 %h", o_vout, o_dout, first);
    end
  endtask

  task automatic test_vc0_only();
    flush();
    for (int i = 1; i <= 5; i++) q0.push_back(BW'(i));
    drive_fifos();
    for (int i = 0; i < 7; i++) begin
      logic          ev;
      logic [BW-1:0] ed;
      ev = (i < 5);
      ed = (i < 5) ? BW'(i + 1) : BW'(5);
      cycle();
      n_checks++;
      if ({o_pop1, o_vout, o_dout} !== {1'b0, ev, ed}) begin
        n_fails++;
        $display("FAIL vc0_only[%0d]: pop1=%b valid=%b data=%h, required 0 %b %h",
                 i, o_pop1, o_vout, o_dout, ev, ed);
      end
    end
  endtask

  task automatic test_fairness();
    bit exp_seq[12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1};
    bit got[$];
    flush();
    for (int i = 0; i < 8; i++) q0.push_back(mk_word(1'b0));
    for (int i = 0; i < 4; i++) q1.push_back(mk_word(1'b1));
    drive_fifos();
    for (int i = 0; i < 14; i++) begin
      cycle();
      n_checks++;
      if ({o_pop0, o_pop1, o_vout, o_dout} !== {x_pop0, x_pop1, m_vout, m_dout}) begin
        n_fails++;
        $display("FAIL fairness_model[%0d]: pops=%b%b valid=%b data=%h, required %b%b %b %h",
                 i, o_pop0, o_pop1, o_vout, o_dout, x_pop0, x_pop1, m_vout, m_dout);
      end
      if (o_vout === 1'b1) got.push_back(o_dout[VC_BIT]);
    end
    n_checks++;
    if (got.size() != 12) begin
      n_fails++;
      $display("FAIL fairness_count: %0d words, required 12", got.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (got[i] !== exp_seq[i]) begin
          n_fails++;
          $display("FAIL fairness_order[%0d]: vc=%0d, required %0d", i, got[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    flush();
    for (int i = 0; i < 6; i++) q0.push_back(mk_word(1'b0));
    for (int i = 0; i < 3; i++) q1.push_back(mk_word(1'b1));
    drive_fifos();
    for (int i = 0; i < 3; i++) cycle();
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if ({o_pop0, o_pop1, o_vout} !== 3'b000) begin
        n_fails++;
        $display("FAIL pause[%0d]: pops=%b%b valid=%b, required 00 0", i, o_pop0, o_pop1, o_vout);
      end
    end
    bus.pause = 1'b0;
    cycle();
    n_checks++;
    if ({o_pop0, o_pop1} !== 2'b01) begin
      n_fails++;
      $display("FAIL pause_release_pop: pops=%b%b, required 01", o_pop0, o_pop1);
    end
    n_checks++;
    if ({o_vout, o_dout[VC_BIT]} !== 2'b11) begin
      n_fails++;
      $display("FAIL pause_release_word: valid=%b vc=%b, required 1 1", o_vout, o_dout[VC_BIT]);
    end
  endtask

  task automatic test_vc1_drain();
    flush();
    for (int i = 0; i < 6; i++) q0.push_back(mk_word(1'b0));
    q1.push_back(mk_word(1'b1));
    drive_fifos();
    for (int i = 0; i < 3; i++) cycle();
    // The lone VC1 word leaves just as the forced slot comes due
    q1.delete();
    drive_fifos();
    cycle();
    n_checks++;
    if ({o_pop0, o_pop1} !== {x_pop0, x_pop1} || {o_pop0, o_pop1} !== 2'b00) begin
      n_fails++;
      $display("FAIL drain_force: pops=%b%b, required 00", o_pop0, o_pop1);
    end
    cycle();
    n_checks++;
    if ({o_pop0, o_pop1} !== 2'b10) begin
      n_fails++;
      $display("FAIL drain_resume: pops=%b%b, required 10", o_pop0, o_pop1);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_pops[4] = '{2'b10, 2'b10, 2'b10, 2'b01};
    flush();
    for (int i = 0; i < 10; i++) q0.push_back(mk_word(1'b0));
    for (int i = 0; i < 4; i++) q1.push_back(mk_word(1'b1));
    drive_fifos();
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if ({o_pop0, o_pop1} !== exp_pops[i]) begin
        n_fails++;
        $display("FAIL reset_mid[%0d]: pops=%b%b, required %b", i, o_pop0, o_pop1, exp_pops[i]);
      end
    end
  endtask

  task automatic test_random();
    flush();
    for (int i = 0; i < 600; i++) begin
      if (q0.size() < 8 && $urandom_range(0, 99) < 55) q0.push_back(mk_word(1'b0));
      if (q1.size() < 8 && $urandom_range(0, 99) < 40) q1.push_back(mk_word(1'b1));
      drive_fifos();
      bus.pause = ($urandom_range(0, 99) < 20);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
      n_checks++;
      if ({o_pop0, o_pop1, o_vout, o_dout} !== {x_pop0, x_pop1, m_vout, m_dout}) begin
        n_fails++;
        $display("FAIL random[%0d]: pops=%b%b valid=%b data=%h, required %b%b %b %h",
                 i, o_pop0, o_pop1, o_vout, o_dout, x_pop0, x_pop1, m_vout, m_dout);
      end
    end
    reset = 1'b0;
    bus.pause = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.pause = 1'b0;
    m_run0 = 0;
    m_owe1 = 1'b0;
    m_dout = '0;
    m_vout = 1'b0;
    drive_fifos();
    test_reset();
    test_vc0_only();
    test_fairness();
    test_backpressure();
    test_vc1_drain();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
